// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS.CC stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Limits are held as tens/units digit pairs so no counter ever leaves BCD.
  localparam bcd_digit_t CS_MAX_TENS   = 4'd9;
  localparam bcd_digit_t CS_MAX_UNITS  = 4'd9;
  localparam bcd_digit_t SEC_MAX_TENS  = 4'd5;
  localparam bcd_digit_t SEC_MAX_UNITS = 4'd9;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/status bundle between the stopwatch and its user.
// The LAP_HOLD_EN macro adds the i_lap pulse.
interface stopwatch_counter_if;

  logic       i_startstop;
  logic       i_clear;
  logic       i_base_tick;
`ifdef LAP_HOLD_EN
  logic       i_lap;
`endif
  logic       o_timerenb;
  logic       o_running;
  logic [7:0] o_min_bcd;
  logic [7:0] o_sec_bcd;
  logic [7:0] o_cs_bcd;
  logic       o_overflow;

  modport master (
`ifdef LAP_HOLD_EN
    output i_lap,
`endif
    output i_startstop, i_clear, i_base_tick,
    input  o_timerenb, o_running, o_min_bcd, o_sec_bcd, o_cs_bcd, o_overflow
  );

  modport slave (
`ifdef LAP_HOLD_EN
    input  i_lap,
`endif
    input  i_startstop, i_clear, i_base_tick,
    output o_timerenb, o_running, o_min_bcd, o_sec_bcd, o_cs_bcd, o_overflow
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after {MAX_TENS, MAX_UNITS}.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_digit_t MAX_TENS  = 4'd9,
  parameter bcd_digit_t MAX_UNITS = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry_out
);

  bcd_digit_t tens;
  bcd_digit_t units;
  logic       at_max;

  assign at_max    = (tens == MAX_TENS) && (units == MAX_UNITS);
  assign carry_out = inc && at_max;
  assign value     = {tens, units};

  // Units roll 9->0 into tens except at the limit, where the pair returns to 00.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= '0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Run/pause stopwatch counting 10 ms base-tick level changes into MM:SS.CC BCD.
// LAP_HOLD_EN adds a lap-hold display freeze driven by i_lap.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MINUTES = 59,
  parameter int WRAP        = 1
) (
  input logic               i_sclk,
  input logic               i_reset,
  stopwatch_counter_if.slave sw
);

  localparam bcd_digit_t MIN_TENS  = bcd_digit_t'(MAX_MINUTES / 10);
  localparam bcd_digit_t MIN_UNITS = bcd_digit_t'(MAX_MINUTES % 10);
  localparam bit         SATURATE  = (WRAP == 0);

  sw_state_t  state;
  sw_state_t  next_state;
  logic       running;
  logic       tick_q;
  logic       tick_edge;
  logic       count_en;
  logic       at_full;
  logic       full_hit;
  logic       saturate_hit;
  logic       do_clear;
  logic       cs_inc;
  logic       cs_carry;
  logic       sec_carry;
  logic       min_carry;
  logic       overflow;
  logic [7:0] cs_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;

  assign tick_edge    = sw.i_base_tick ^ tick_q;
  assign count_en     = tick_edge && (state == RUNNING);
  assign at_full      = (cs_bcd == {CS_MAX_TENS, CS_MAX_UNITS})
                     && (sec_bcd == {SEC_MAX_TENS, SEC_MAX_UNITS})
                     && (min_bcd == {MIN_TENS, MIN_UNITS});
  assign full_hit     = count_en && at_full;
  // In saturating mode the count is frozen at its maximum instead of wrapping.
  assign saturate_hit = SATURATE && full_hit;
  assign cs_inc       = count_en && !saturate_hit;
  assign do_clear     = sw.i_clear && (state != RUNNING);

  always_ff @(posedge i_sclk) begin
    if (i_reset) tick_q <= 1'b0;
    else         tick_q <= sw.i_base_tick;
  end

  always_ff @(posedge i_sclk) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Clear beats startstop outside RUNNING; inside RUNNING clear is ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sw.i_clear)          next_state = IDLE;
        else if (sw.i_startstop) next_state = RUNNING;
      end
      RUNNING: begin
        if (sw.i_startstop || saturate_hit) next_state = PAUSED;
      end
      PAUSED: begin
        if (sw.i_clear)          next_state = IDLE;
        else if (sw.i_startstop) next_state = RUNNING;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUNNING);
  end

  always_ff @(posedge i_sclk) begin
    if (i_reset || do_clear) overflow <= 1'b0;
    else if (SATURATE)       overflow <= overflow | full_hit;
    else                     overflow <= full_hit;
  end

  bcd_digit_counter #(.MAX_TENS(CS_MAX_TENS), .MAX_UNITS(CS_MAX_UNITS)) u_cs (
    .clk(i_sclk), .reset(i_reset), .clear(do_clear),
    .inc(cs_inc), .value(cs_bcd), .carry_out(cs_carry)
  );

  bcd_digit_counter #(.MAX_TENS(SEC_MAX_TENS), .MAX_UNITS(SEC_MAX_UNITS)) u_sec (
    .clk(i_sclk), .reset(i_reset), .clear(do_clear),
    .inc(cs_carry), .value(sec_bcd), .carry_out(sec_carry)
  );

  bcd_digit_counter #(.MAX_TENS(MIN_TENS), .MAX_UNITS(MIN_UNITS)) u_min (
    .clk(i_sclk), .reset(i_reset), .clear(do_clear),
    .inc(sec_carry), .value(min_bcd), .carry_out(min_carry)
  );

  assign sw.o_timerenb = running;
  assign sw.o_running  = running;
  assign sw.o_overflow = overflow;

`ifdef LAP_HOLD_EN
  logic       hold;
  logic [7:0] snap_cs;
  logic [7:0] snap_sec;
  logic [7:0] snap_min;
  logic       unused_min_carry;

  assign unused_min_carry = min_carry;

  // Any path into IDLE drops the hold; outside RUNNING a lap can only release.
  always_ff @(posedge i_sclk) begin
    if (i_reset || (next_state == IDLE)) begin
      hold <= 1'b0;
    end else if (sw.i_lap) begin
      if (state == RUNNING) begin
        hold     <= !hold;
        snap_cs  <= cs_bcd;
        snap_sec <= sec_bcd;
        snap_min <= min_bcd;
      end else begin
        hold <= 1'b0;
      end
    end
  end

  assign sw.o_cs_bcd  = hold ? snap_cs  : cs_bcd;
  assign sw.o_sec_bcd = hold ? snap_sec : sec_bcd;
  assign sw.o_min_bcd = hold ? snap_min : min_bcd;
`else
  logic unused_min_carry;

  assign unused_min_carry = min_carry;
  assign sw.o_cs_bcd      = cs_bcd;
  assign sw.o_sec_bcd     = sec_bcd;
  assign sw.o_min_bcd     = min_bcd;
`endif

endmodule
